dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Frequency-sweep sequencer for the CoreDDS core. It programs a start phase and then steps the DDS frequency offset through a list of equally spaced values, holding each value for a programmable dwell time. Supported patterns are single-shot, sawtooth-repeat and triangle. It sits between the host register bank and the DDS `FREQ_OFFSET`/`PH_OFFSET` write ports. It waits for the DDS LUT initialization to complete before issuing any write.

## Interface
- `FREQ_OFFSET_BITS`, 24: width of frequency start/step/offset.
- `PH_OFFSET_BITS`, 24: width of phase start/offset.
- `DWELL_BITS`, 16: width of dwell counter.
- `STEP_BITS`, 12: width of step count/index.

Ports:
- `CLK`  in  1: single clock. All logic is on rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `START`  in  1: sweep request, sampled per cycle.
- `ABORT`  in  1: terminate sweep.
- `MODE`  in  2: 0 single, 1 sawtooth repeat, 2 triangle, 3 treated as 0.
- `FREQ_START`  in  FREQ_OFFSET_BITS: first frequency offset.
- `FREQ_STEP`  in  FREQ_OFFSET_BITS: increment per step, two's-complement.
- `NUM_STEPS`  in  STEP_BITS: number of distinct frequencies N. 0 is treated as 1.
- `DWELL`  in  DWELL_BITS: cycles between successive writes D. 0 is treated as 1.
- `PH_START`  in  PH_OFFSET_BITS: phase offset written at sweep start.
- `INIT_OVER`  in  1: DDS LUT-init-complete pulse.
- `FREQ_OFFSET`  out  FREQ_OFFSET_BITS: to DDS.
- `FREQ_OFFSET_WE`  out  1: to DDS.
- `PH_OFFSET`  out  PH_OFFSET_BITS: to DDS.
- `PH_OFFSET_WE`  out  1: to DDS.
- `BUSY`  out  1: sweep in progress.
- `DONE`  out  1: one-cycle pulse when a single sweep completes.
- `STEP_IDX`  out  STEP_BITS: index of the frequency currently applied.

## Operation
- **Ready flag.** The sticky `ready` flag is set by `INIT_OVER`=1 and cleared only by `RST`.
- **Configuration latch.** `MODE`, `FREQ_START`, `FREQ_STEP`, N, D and `PH_START` are latched when `START` is accepted. Input changes during a sweep have no effect.
- **States.** IDLE, WAIT_INIT, LOAD, DWELL, TURN.
  - **IDLE:** `BUSY`=0. `START`=1 with `ABORT`=0 latches the configuration, clears the index and direction (up), and goes to WAIT_INIT.
  - **WAIT_INIT:** waits until `ready`, or `INIT_OVER` in the same cycle, then goes to LOAD.
  - **LOAD:** one cycle.
    - `FREQ_OFFSET_WE`=1 with the current frequency. On the first LOAD of a sweep, `PH_OFFSET_WE`=1 with `PH_START` in the same cycle.
    - The dwell counter is loaded with D−1, then the state goes to DWELL.
  - **DWELL:** the counter decrements each cycle. At 0 the next frequency is computed and the state goes to LOAD. The endpoint cases are:
    - Single, last index: DONE.
    - Sawtooth, last index: frequency returns to `FREQ_START`, index 0.
    - Triangle, at an endpoint: go to TURN (only when N>1).
  - **TURN:** not a separate cycle. The direction flips and the index moves one step back toward the other endpoint, so endpoints are emitted once per half period.
- **Frequency arithmetic.** next = current ± `FREQ_STEP`, modulo 2^`FREQ_OFFSET_BITS`. Wrap is silent. `STEP_IDX` tracks 0..N−1.
- **N=1 cases.** Sawtooth or triangle rewrites the same frequency every D cycles. Single-shot finishes after one dwell.
- **DONE (single-shot only).** In the cycle the last dwell expires, `DONE`=1 and `BUSY`=0, and the state returns to IDLE. `FREQ_OFFSET` holds the last value.
- **ABORT.** `ABORT`=1 in any state forces IDLE on the next edge.
  - No `DONE` and no further WE. An abort in the same cycle as a LOAD suppresses that LOAD's WE.
  - `ABORT` wins over `START`.
- **Repeated START.** `START` while `BUSY` is ignored. Repeat modes run until `ABORT`.
- **Reset.** `RST` mid-sweep returns to IDLE immediately (async) and drops `ready`. Reset values of outputs:
  - `FREQ_OFFSET`=0, `PH_OFFSET`=0.
  - `FREQ_OFFSET_WE`=0, `PH_OFFSET_WE`=0.
  - `BUSY`=0, `DONE`=0, `STEP_IDX`=0.

## Timing
- All outputs are registered.
- `START` sampled at edge t with `ready`=1:
  - `BUSY`=1 from t+1.
  - First WE pair asserted in cycle t+2.
- Successive `FREQ_OFFSET_WE` pulses are spaced exactly D cycles.
- Each WE is exactly 1 cycle wide. `FREQ_OFFSET`/`PH_OFFSET` are valid in the WE cycle and held afterwards.
- In single mode, `DONE` arrives D cycles after the last WE.
- If `ready`=0, the first WE comes 1 cycle after the `INIT_OVER` pulse.
- A sweep may restart on the cycle after `DONE`.

## Test plan
1. **Init gating.** `START` before `INIT_OVER`: no WE. `INIT_OVER` pulse at cycle 50: `FREQ_OFFSET_WE` and `PH_OFFSET_WE` at cycle 51, `PH_OFFSET`=`PH_START`=0x000400.
2. **Single sweep.** Start=0x001000, step=0x000100, N=4, D=3: WE at t+2, t+5, t+8, t+11 with values 0x1000/0x1100/0x1200/0x1300. `DONE` at t+14, `BUSY` falls at t+14, `PH_OFFSET_WE` only once.
3. **Triangle.** N=3, D=1, start=0x10, step=0x10: `FREQ_OFFSET` sequence 0x10,0x20,0x30,0x20,0x10,0x20…. `STEP_IDX` 0,1,2,1,0,1.
4. **Wrap and negative step.** Start=0xFFFFF0, step=0x000010, N=3, sawtooth: 0xFFFFF0, 0x000000, 0x000010, 0xFFFFF0…. Step=0xFFFFF0 (−16) from 0x000000 gives 0xFFFFF0.
5. **Abort.** `ABORT` coincident with a LOAD cycle: no WE that cycle, `BUSY`=0 next cycle, no `DONE`. `START` while `BUSY` produces no restart.
6. **Reset.** `RST` mid-DWELL: all outputs 0 asynchronously. After release, `START` waits for a new `INIT_OVER`. N=0/D=0 behaves as N=1/D=1.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for CoreDDS: writes PH_START once, then steps FREQ_OFFSET through
// N equally spaced values (single, sawtooth or triangle), one write every D cycles.
module dds_sweep_ctrl #(
  parameter int FREQ_OFFSET_BITS = 24,
  parameter int PH_OFFSET_BITS   = 24,
  parameter int DWELL_BITS       = 16,
  parameter int STEP_BITS        = 12
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        ABORT,
  input  logic [1:0]                  MODE,
  input  logic [FREQ_OFFSET_BITS-1:0] FREQ_START,
  input  logic [FREQ_OFFSET_BITS-1:0] FREQ_STEP,
  input  logic [STEP_BITS-1:0]        NUM_STEPS,
  input  logic [DWELL_BITS-1:0]       DWELL,
  input  logic [PH_OFFSET_BITS-1:0]   PH_START,
  input  logic                        INIT_OVER,
  output logic [FREQ_OFFSET_BITS-1:0] FREQ_OFFSET,
  output logic                        FREQ_OFFSET_WE,
  output logic [PH_OFFSET_BITS-1:0]   PH_OFFSET,
  output logic                        PH_OFFSET_WE,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [STEP_BITS-1:0]        STEP_IDX,
  output logic [1:0]                  DBG_STATE
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_INIT, S_LOAD, S_DWELL} state_t;

  localparam logic [STEP_BITS-1:0]  STEP_ONE  = 1;
  localparam logic [DWELL_BITS-1:0] DWELL_ONE = 1;

  state_t                        state_q, state_d;
  logic                          ready_q, ready_d;
  logic [1:0]                    mode_q, mode_d;
  logic [FREQ_OFFSET_BITS-1:0]   fstart_q, fstart_d, fstep_q, fstep_d, freq_q, freq_d;
  logic [PH_OFFSET_BITS-1:0]     phs_q, phs_d, ph_q, ph_d;
  logic [STEP_BITS-1:0]          nm1_q, nm1_d, idx_q, idx_d;
  logic [DWELL_BITS-1:0]         dm1_q, dm1_d, cnt_q, cnt_d;
  logic                          dir_q, dir_d;
  logic                          fwe_q, fwe_d, pwe_q, pwe_d, busy_q, busy_d, done_q, done_d;

  logic init_ok, cnt_zero, last, single, saw, tri_m, turn, go_down, hold;

  // WE pulses are one-cycle write strobes; FREQ_OFFSET/PH_OFFSET are valid with them and held after.
  assign init_ok  = ready_q | INIT_OVER;
  assign cnt_zero = (cnt_q == '0);
  assign last     = (idx_q == nm1_q);
  assign single   = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign saw      = (mode_q == 2'd1);
  assign tri_m    = (mode_q == 2'd2);
  // Triangle reverses at either endpoint; dir_q=1 means counting down.
  assign turn     = tri_m && (nm1_q != '0) && (dir_q ? (idx_q == '0) : last);
  assign go_down  = tri_m && (dir_q ^ turn);
  assign hold     = tri_m && (nm1_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      mode_q   <= '0;
      fstart_q <= '0;
      fstep_q  <= '0;
      freq_q   <= '0;
      phs_q    <= '0;
      ph_q     <= '0;
      nm1_q    <= '0;
      idx_q    <= '0;
      dm1_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      fwe_q    <= 1'b0;
      pwe_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstep_q  <= fstep_d;
      freq_q   <= freq_d;
      phs_q    <= phs_d;
      ph_q     <= ph_d;
      nm1_q    <= nm1_d;
      idx_q    <= idx_d;
      dm1_q    <= dm1_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      fwe_q    <= fwe_d;
      pwe_q    <= pwe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:      if (START) state_d = S_WAIT_INIT;
        S_WAIT_INIT: if (init_ok) state_d = S_LOAD;
        default: begin
          if (!cnt_zero)          state_d = S_DWELL;
          else if (single && last) state_d = S_IDLE;
          else                    state_d = S_LOAD;
        end
      endcase
    end
  end

  always_comb begin
    ready_d  = ready_q | INIT_OVER;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstep_d  = fstep_q;
    freq_d   = freq_q;
    phs_d    = phs_q;
    ph_d     = ph_q;
    nm1_d    = nm1_q;
    idx_d    = idx_q;
    dm1_d    = dm1_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    fwe_d    = 1'b0;
    pwe_d    = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    if (!ABORT) begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            mode_d   = MODE;
            fstart_d = FREQ_START;
            fstep_d  = FREQ_STEP;
            phs_d    = PH_START;
            nm1_d    = (NUM_STEPS == '0) ? '0 : NUM_STEPS - STEP_ONE;
            dm1_d    = (DWELL == '0) ? '0 : DWELL - DWELL_ONE;
            idx_d    = '0;
            dir_d    = 1'b0;
          end
        end
        S_WAIT_INIT: begin
          if (init_ok) begin
            freq_d = fstart_q;
            ph_d   = phs_q;
            fwe_d  = 1'b1;
            pwe_d  = 1'b1;
            cnt_d  = dm1_q;
          end
        end
        default: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - DWELL_ONE;
          end else if (single && last) begin
            done_d = 1'b1;
          end else begin
            fwe_d = 1'b1;
            cnt_d = dm1_q;
            dir_d = dir_q ^ turn;
            if (saw && last) begin
              idx_d  = '0;
              freq_d = fstart_q;
            end else if (go_down) begin
              idx_d  = idx_q - STEP_ONE;
              freq_d = freq_q - fstep_q;
            end else if (!hold) begin
              idx_d  = idx_q + STEP_ONE;
              freq_d = freq_q + fstep_q;
            end
          end
        end
      endcase
    end
  end

  assign FREQ_OFFSET    = freq_q;
  assign FREQ_OFFSET_WE = fwe_q;
  assign PH_OFFSET      = ph_q;
  assign PH_OFFSET_WE   = pwe_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign STEP_IDX       = idx_q;
  assign DBG_STATE      = state_q;
endmodule
